gpr_xfer_sequencer: RTL
=======================

Name: gpr_xfer_sequencer

Overview:
- Sequences one register-transfer operation at a time across the bank of general-purpose register cells on the shared tri-state operand buses.
- Accepts a request (rs1, rs2, rd, mode) and drives per-register one-hot enables: read A, read B, write, and through-C.
- Waits for the ALU to finish, then commits the write.
- Sits between the instruction decoder and the GPR bank. It is the only source of GPR enables, which guarantees at most one driver per bus.

Parameters:
- NREG, 16, number of GPR cells controlled (2..32).
- IDX_W, 4, width of register index fields; NREG <= 2**IDX_W.
- TIMEOUT, 15, maximum EXEC cycles to wait for alu_done before aborting (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_rs1  in  IDX_W  register driven onto bus A.
- req_rs2  in  IDX_W  register driven onto bus B.
- req_rd  in  IDX_W  destination register, or source register in THRU mode.
- req_mode  in  2  0=ALU (read A/B, write rd), 1=READ_ONLY (read A/B, no write), 2=THRU (rd data out on C, no write), 3=reserved.
- alu_start  out  1  one-cycle pulse when operands are on buses A/B.
- alu_done  in  1  ALU result valid on the data_in bus.
- rd_A_en  out  NREG  one-hot or zero; A-bus output enable per GPR.
- rd_B_en  out  NREG  one-hot or zero; B-bus output enable per GPR.
- wt_en  out  NREG  one-hot or zero; write enable per GPR.
- through_C_en  out  NREG  one-hot or zero; C pass-through select per GPR.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: operation aborted.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous active-low.
- Reset values: state=IDLE; all enables=0; alu_start=0; done=0; err=0; busy=0; req_ready=1 (combinational from IDLE).
- Handshake: accept when req_valid && req_ready on a rising edge. Capture rs1/rs2/rd/mode into internal registers. Inputs are ignored at all other times.
- Enables are decoded only from the state register and latched fields. There is no combinational path from req_* to any enable.
- States and transitions:
  - IDLE: accept → READ when mode is 0 or 1; accept → WRITE when mode is 2.
  - READ (1 cycle): rd_A_en[rs1]=1, rd_B_en[rs2]=1, alu_start=1. Mode 0 → EXEC. Mode 1 → DONE.
  - EXEC: hold rd_A_en/rd_B_en. Clear the cycle counter on entry and increment it each cycle.
    - alu_done=1 → WRITE.
    - Counter reaches TIMEOUT without alu_done → DONE with err=1; no write occurs.
    - alu_done in the same cycle as the timeout: alu_done wins.
  - WRITE (1 cycle): mode 0 → wt_en[rd]=1 only. Mode 2 → wt_en[rd]=1 and through_C_en[rd]=1, so the cell outputs on C and suppresses its write. A/B enables are 0. Next state DONE.
  - DONE (1 cycle): done=1; err as computed; all enables 0. Next state IDLE.
- Operation latencies, accept edge to done pulse:
  - Mode 0: 3 + k cycles, where k = EXEC cycles up to and including alu_done (k>=1).
  - Mode 1: 2 cycles.
  - Mode 2: 2 cycles.
- rs1==rs2 is legal: the same cell drives both A and B.
- rd equal to rs1 or rs2 is legal: reads complete before WRITE.
- Out-of-range index (>= NREG) in any used field: accept, skip READ/EXEC/WRITE, go directly to DONE with err=1. No enable is asserted.
- mode=3: same as out-of-range (err=1, no enables).
- Invariants: at most one bit set in each enable vector. wt_en is never asserted in the same cycle as any rd_A_en or rd_B_en.
- Reset mid-operation: immediate return to IDLE with all enables cleared asynchronously. No done pulse is generated for the aborted operation.
- err is valid only with done and is 0 otherwise.

Decomposition:
- Shared package gpr_pkg:
  - state encoding (IDLE, READ, EXEC, WRITE, DONE);
  - mode constants (MODE_ALU, MODE_RDONLY, MODE_THRU);
  - default NREG/IDX_W.
- One sub-module: gpr_onehot_dec (IDX_W index + enable → NREG one-hot with range check, outputs zero when out of range). Instantiated four times.

Test Plan:
- Reset mid-EXEC: rs1=3, rs2=5, rd=7, mode 0, alu_done never; drop rst_n after 2 EXEC cycles → all enables 0 asynchronously, req_ready=1, no done.
- Mode 0: rs1=3, rs2=5, rd=7, alu_done 2 cycles after alu_start:
  - rd_A_en=0x0008 and rd_B_en=0x0020 from the READ cycle through EXEC;
  - then wt_en=0x0080 for 1 cycle;
  - done at accept+5, err=0.
- Mode 2 THRU: rd=4 → the cycle after accept, wt_en=0x0010 and through_C_en=0x0010; done the following cycle; A/B enables stay 0.
- Timeout: TIMEOUT=3, mode 0, alu_done held 0 → exactly 3 EXEC cycles, then done=1, err=1; wt_en is never asserted.
- Out-of-range: NREG=16, IDX_W=5, rs1=20 → done=1, err=1 one cycle after accept; no enable ever asserted.
- Back-to-back: req_valid held high with two requests → second accepted on the first IDLE cycle after DONE; req_ready=0 throughout the first operation.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types and defaults for the GPR transfer sequencer.
package gpr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_ALU    = 2'd0;
  localparam logic [1:0] MODE_RDONLY = 2'd1;
  localparam logic [1:0] MODE_THRU   = 2'd2;

  localparam int DEF_NREG    = 16;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/gpr_xfer_sequencer_if.sv
// Request, ALU handshake and GPR enable bundle between decoder/ALU side and the sequencer.
interface gpr_xfer_sequencer_if
  import gpr_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int IDX_W = DEF_IDX_W
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_rs1;
  logic [IDX_W-1:0] req_rs2;
  logic [IDX_W-1:0] req_rd;
  logic [1:0]       req_mode;
  logic             alu_start;
  logic             alu_done;
  logic [NREG-1:0]  rd_A_en;
  logic [NREG-1:0]  rd_B_en;
  logic [NREG-1:0]  wt_en;
  logic [NREG-1:0]  through_C_en;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_mode, alu_done,
    input  req_ready, alu_start, rd_A_en, rd_B_en, wt_en, through_C_en, done, err, busy
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_mode, alu_done,
    output req_ready, alu_start, rd_A_en, rd_B_en, wt_en, through_C_en, done, err, busy
  );
endinterface

// File: rtl/gpr_onehot_dec.sv
// Index-to-one-hot decoder; indices at or above NREG decode to all zeros.
module gpr_onehot_dec #(
  parameter int NREG  = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end
endmodule

// File: rtl/gpr_xfer_sequencer.sv
// Sequences one GPR read/execute/write transfer at a time; sole source of GPR bus enables.
//   state    | meaning
//   IDLE     | ready for a request
//   READ     | rs1 on A, rs2 on B, alu_start pulse
//   EXEC     | operands held, waiting for alu_done or timeout
//   WRITE    | wt_en[rd] (plus through_C_en[rd] in THRU mode)
//   DONE     | done pulse, err qualifies abort
module gpr_xfer_sequencer
  import gpr_pkg::*;
#(
  parameter int NREG    = DEF_NREG,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst_n,
  gpr_xfer_sequencer_if.slave bus
);
  localparam logic [IDX_W:0] NREG_LIM = (IDX_W+1)'(NREG);
  localparam logic [7:0]     CNT_INIT = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic [1:0]       mode_q;
  logic [7:0]       cnt_q;
  logic             err_q, err_nxt;
  logic             accept;
  logic             rs1_ok, rs2_ok, rd_ok;

  assign accept = (state == ST_IDLE) && bus.req_valid;
  assign rs1_ok = {1'b0, bus.req_rs1} < NREG_LIM;
  assign rs2_ok = {1'b0, bus.req_rs2} < NREG_LIM;
  assign rd_ok  = {1'b0, bus.req_rd}  < NREG_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      mode_q <= MODE_ALU;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (accept) begin
        rs1_q  <= bus.req_rs1;
        rs2_q  <= bus.req_rs2;
        rd_q   <= bus.req_rd;
        mode_q <= bus.req_mode;
      end
      // Down-counter: loaded in READ so the first EXEC cycle sees TIMEOUT-1.
      if (state == ST_READ) begin
        cnt_q <= CNT_INIT;
      end else if (state == ST_EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_mode)
            MODE_ALU:    state_nxt = (rs1_ok && rs2_ok && rd_ok) ? ST_READ : ST_DONE;
            MODE_RDONLY: state_nxt = (rs1_ok && rs2_ok) ? ST_READ : ST_DONE;
            MODE_THRU:   state_nxt = rd_ok ? ST_WRITE : ST_DONE;
            default:     state_nxt = ST_DONE;
          endcase
          err_nxt = (state_nxt == ST_DONE);
        end
      end
      ST_READ:  state_nxt = (mode_q == MODE_ALU) ? ST_EXEC : ST_DONE;
      ST_EXEC: begin
        if (bus.alu_done) begin
          state_nxt = ST_WRITE;
        end else if (cnt_q == '0) begin
          state_nxt = ST_DONE;
          err_nxt   = 1'b1;
        end
      end
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  logic ab_en, w_en, c_en;
  assign ab_en = (state == ST_READ) || (state == ST_EXEC);
  assign w_en  = (state == ST_WRITE);
  assign c_en  = (state == ST_WRITE) && (mode_q == MODE_THRU);

  gpr_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_a (.idx(rs1_q), .en(ab_en), .onehot(bus.rd_A_en));
  gpr_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_b (.idx(rs2_q), .en(ab_en), .onehot(bus.rd_B_en));
  gpr_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_w (.idx(rd_q),  .en(w_en),  .onehot(bus.wt_en));
  gpr_onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dec_c (.idx(rd_q),  .en(c_en),  .onehot(bus.through_C_en));

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.alu_start = (state == ST_READ);
  assign bus.done      = (state == ST_DONE);
  assign bus.err       = err_q;
endmodule
